// File: rtl/wasm_prog_loader.sv
// Loads a length-prefixed WASM program into instruction BRAM, runs the core,
// and latches the run's result code and cycle count for the host.
module wasm_prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              i_restart,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wdata,
    output logic              cpu_rst_n,
    input  logic              i_instr_finish,
    input  logic              i_instr_error,
    input  logic              i_stack_exceed,
    input  logic              i_stack_empty_pop,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_status,
    output logic [CNT_W-1:0]  o_cycle_cnt
);

    // state  | meaning
    // LEN0   | waiting for length low byte
    // LEN1   | waiting for length high byte
    // LOAD   | writing program bytes to BRAM
    // FLUSH  | final BRAM write presented
    // RUN    | core out of reset, counting cycles
    // DONE   | result latched, waiting for restart
    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_LOAD, S_FLUSH, S_RUN, S_DONE
    } state_t;

    localparam logic [16:0]      DEPTH    = 17'(1 << ADDR_W);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic             rdy_en;
    logic [15:0]      len;
    logic [15:0]      idx;
    logic [CNT_W-1:0] run_cnt;
    logic             accept;
    logic [15:0]      len_full;
    logic             len_bad;
    logic             last_byte;
    logic             run_hit;
    logic [2:0]       run_code;
    logic             run_tmo;

    assign s_ready   = rdy_en & ((state == S_LEN0) | (state == S_LEN1) | (state == S_LOAD));
    assign accept    = s_valid & s_ready;
    assign len_full  = {s_data, len[7:0]};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH);
    assign last_byte = (idx == len - 16'd1);
    assign run_tmo   = (run_cnt == TMO_LAST);
    assign o_busy    = (state != S_DONE);
    assign o_done    = (state == S_DONE);

    // Fixed priority among simultaneous core flags.
    always_comb begin
        run_hit  = 1'b1;
        run_code = 3'd0;
        if (i_instr_error)          run_code = 3'd2;
        else if (i_stack_exceed)    run_code = 3'd3;
        else if (i_stack_empty_pop) run_code = 3'd4;
        else if (i_instr_finish)    run_code = 3'd1;
        else                        run_hit  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LEN0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN0:  if (accept) state_nxt = S_LEN1;
            S_LEN1:  if (accept) state_nxt = len_bad ? S_DONE : S_LOAD;
            S_LOAD:  if (accept && last_byte) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_RUN;
            S_RUN:   if (run_hit || run_tmo) state_nxt = S_DONE;
            S_DONE:  if (i_restart) state_nxt = S_LEN0;
            default: state_nxt = S_LEN0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en      <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_wdata  <= '0;
            cpu_rst_n   <= 1'b0;
            o_status    <= 3'd0;
            o_cycle_cnt <= '0;
            len         <= '0;
            idx         <= '0;
            run_cnt     <= '0;
        end else begin
            rdy_en  <= 1'b1;
            bram_we <= 1'b0;
            case (state)
                S_LEN0: if (accept) len[7:0] <= s_data;
                S_LEN1: begin
                    if (accept) begin
                        len[15:8] <= s_data;
                        idx       <= '0;
                        if (len_bad) o_status <= 3'd6;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        bram_we    <= 1'b1;
                        bram_addr  <= idx[ADDR_W-1:0];
                        bram_wdata <= s_data;
                        idx        <= idx + 16'd1;
                    end
                end
                S_FLUSH: begin
                    cpu_rst_n <= 1'b1;
                    run_cnt   <= '0;
                end
                S_RUN: begin
                    if (run_hit) begin
                        o_status    <= run_code;
                        o_cycle_cnt <= run_cnt;
                        cpu_rst_n   <= 1'b0;
                    end else if (run_tmo) begin
                        o_status    <= 3'd5;
                        o_cycle_cnt <= TMO_VAL;
                        cpu_rst_n   <= 1'b0;
                    end else if (run_cnt != '1) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_DONE: if (i_restart) o_status <= 3'd0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wasm_prog_loader.sv
// Bench for wasm_prog_loader: vector table of programs/run outcomes, with a
// write scoreboard fed by the byte driver and drained by a BRAM-port monitor.
module tb_wasm_prog_loader;

    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'd0;
    logic              s_ready;
    logic              i_restart = 1'b0;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_wdata;
    logic              cpu_rst_n;
    logic              i_instr_finish = 1'b0;
    logic              i_instr_error = 1'b0;
    logic              i_stack_exceed = 1'b0;
    logic              i_stack_empty_pop = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic [2:0]        o_status;
    logic [CNT_W-1:0]  o_cycle_cnt;

    wasm_prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .i_restart(i_restart),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .cpu_rst_n(cpu_rst_n),
        .i_instr_finish(i_instr_finish), .i_instr_error(i_instr_error),
        .i_stack_exceed(i_stack_exceed), .i_stack_empty_pop(i_stack_empty_pop),
        .o_busy(o_busy), .o_done(o_done), .o_status(o_status), .o_cycle_cnt(o_cycle_cnt)
    );

    always #5 clk = ~clk;

    // flags: [3] error, [2] stack_exceed, [1] empty_pop, [0] finish; edge_n 0 = no flags
    typedef struct {
        int         len;
        bit         gaps;
        logic [3:0] flags;
        int         edge_n;
        logic [2:0] st;
        int         cnt;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t  wq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rises = 0;
    int   held_cnt = 0;
    logic prev_we = 1'b0;
    logic prev_crst = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin : mon
        wr_t w;
        @(posedge clk);
        #1;
        if (bram_we) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_we: got addr %0h data %0h expected no write", bram_addr, bram_wdata);
            end else begin
                w = wq.pop_front();
                check("wr_addr", 32'(bram_addr), 32'(w.a));
                check("wr_data", 32'(bram_wdata), 32'(w.d));
            end
        end
        if (cpu_rst_n && !prev_crst) begin
            rises++;
            check("crst_after_last_we", 32'(prev_we), 32'd1);
            check("crst_we_low", 32'(bram_we), 32'd0);
        end
        prev_we   = bram_we;
        prev_crst = cpu_rst_n;
    end

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input logic [7:0] b, input int gaps, input bit push, input int addr);
        int t;
        wr_t w;
        repeat (gaps) @(negedge clk);
        t = 0;
        while (!s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("s_ready_wait", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = b;
        if (push) begin
            w.a = ADDR_W'(addr);
            w.d = b;
            wq.push_back(w);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        i_instr_error     = f[3];
        i_stack_exceed    = f[2];
        i_stack_empty_pop = f[1];
        i_instr_finish    = f[0];
    endtask

    task automatic run_vec(input vec_t v);
        int r0;
        int lat;
        int t;
        int g;
        logic [7:0] p3 [3];
        logic [7:0] b;
        p3[0] = 8'h41; p3[1] = 8'h05; p3[2] = 8'h0B;
        r0 = rises;
        g  = v.gaps ? int'($urandom_range(0, 3)) : 0;
        send_byte(8'(v.len), g, 1'b0, 0);
        g  = v.gaps ? int'($urandom_range(0, 3)) : 0;
        send_byte(8'(v.len >> 8), g, 1'b0, 0);
        if (v.st != 3'd6) begin
            for (int i = 0; i < v.len; i++) begin
                b = (i < 3) ? p3[i] : 8'($urandom);
                g = v.gaps ? int'($urandom_range(0, 3)) : 0;
                send_byte(b, g, 1'b1, i);
            end
            t = 0;
            while (!cpu_rst_n && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("crst_rise", 32'(cpu_rst_n), 32'd1);
            lat = 0;
            while (!o_done && lat < 100) begin
                if (v.edge_n > 0 && lat == v.edge_n - 1) set_flags(v.flags);
                @(negedge clk);
                set_flags(4'd0);
                lat++;
            end
            check("done_latency", 32'(lat), 32'((v.edge_n > 0) ? v.edge_n : TIMEOUT));
            check("cycle_cnt", o_cycle_cnt, 32'(v.cnt));
            held_cnt = v.cnt;
        end else begin
            t = 0;
            while (!o_done && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("no_crst_rise", 32'(rises), 32'(r0));
        end
        check("done", 32'(o_done), 32'd1);
        check("busy_low", 32'(o_busy), 32'd0);
        check("status", 32'(o_status), 32'(v.st));
        check("crst_low", 32'(cpu_rst_n), 32'd0);
        i_restart = 1'b1;
        @(negedge clk);
        i_restart = 1'b0;
        check("restart_busy", 32'(o_busy), 32'd1);
        check("restart_status", 32'(o_status), 32'd0);
        if (v.st != 3'd6) check("restart_cnt_hold", o_cycle_cnt, 32'(held_cnt));
    endtask

    task automatic reset_checks();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_we", 32'(bram_we), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_wdata", 32'(bram_wdata), 32'd0);
        check("rst_crst", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd1);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_status", 32'(o_status), 32'd0);
        check("rst_cnt", o_cycle_cnt, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        vec_t hv;
        vecs[0] = '{len: 3,     gaps: 0, flags: 4'b0001, edge_n: 11, st: 3'd1, cnt: 10};
        vecs[1] = '{len: 3,     gaps: 1, flags: 4'b0001, edge_n: 11, st: 3'd1, cnt: 10};
        vecs[2] = '{len: 0,     gaps: 0, flags: 4'b0000, edge_n: 0,  st: 3'd6, cnt: 0};
        vecs[3] = '{len: 17,    gaps: 0, flags: 4'b0000, edge_n: 0,  st: 3'd6, cnt: 0};
        vecs[4] = '{len: 1,     gaps: 0, flags: 4'b0000, edge_n: 0,  st: 3'd5, cnt: 20};
        vecs[5] = '{len: 2,     gaps: 0, flags: 4'b1101, edge_n: 3,  st: 3'd2, cnt: 2};
        vecs[6] = '{len: 2,     gaps: 1, flags: 4'b0011, edge_n: 5,  st: 3'd4, cnt: 4};
        vecs[7] = '{len: 16,    gaps: 1, flags: 4'b0100, edge_n: 1,  st: 3'd3, cnt: 0};
        vecs[8] = '{len: 256,   gaps: 0, flags: 4'b0000, edge_n: 0,  st: 3'd6, cnt: 0};
        vecs[9] = '{len: 5,     gaps: 0, flags: 4'b0010, edge_n: 20, st: 3'd4, cnt: 19};

        repeat (2) @(negedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_cycle_not_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("ready_after_reset", 32'(s_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Abort a load after two data bytes, then run a clean 2-byte program.
        send_byte(8'h05, 0, 1'b0, 0);
        send_byte(8'h00, 0, 1'b0, 0);
        send_byte(8'hAA, 0, 1'b1, 0);
        send_byte(8'hBB, 1, 1'b1, 1);
        rst_n = 1'b0;
        #1;
        reset_checks();
        wq.delete();
        held_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        hv = '{len: 2, gaps: 0, flags: 4'b0001, edge_n: 4, st: 3'd1, cnt: 3};
        run_vec(hv);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(wq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
